tinker_dmem: RTL and testbench

//  Parametrised Tinker data/instruction memory with a latency-configurable, valid/ready load-store port and a combinational fetch port.

---
 rtl/tinker_dmem.sv | 198 +++++++++++++++++++
 tb/tb_tinker_dmem.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tinker_dmem.sv
// Tinker byte-addressed memory: latency-configurable valid/ready load/store port
// plus a combinational 32-bit instruction fetch port.
module tinker_dmem #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned MEM_BYTES = 524288,
    parameter int unsigned LATENCY   = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic [31:0]       fetch_instr
);

    localparam int unsigned MEM_AW = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
    localparam int unsigned NB_MAX = DATA_W / 8;
    localparam int unsigned CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int unsigned AX_W   = ADDR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic              exec_c;
    logic              accept_c;

    logic              lat_we;
    logic              lat_signed;
    logic [ADDR_W-1:0] lat_addr;
    logic [1:0]        lat_size;
    logic [DATA_W-1:0] lat_wdata;

    logic              acc_we;
    logic              acc_signed;
    logic [ADDR_W-1:0] acc_addr;
    logic [1:0]        acc_size;
    logic [DATA_W-1:0] acc_wdata;
    logic [63:0]       wpad_c;

    logic [3:0]        nbytes_c;
    logic [MEM_AW-1:0] base_c;
    logic              err_c;
    logic [DATA_W-1:0] ldata_c;
    logic [MEM_AW-1:0] fbase_c;

    logic [7:0]        mem [MEM_BYTES];

    assign req_ready = (state == S_IDLE) && !reset;
    assign accept_c  = req_valid && req_ready;

    // With LATENCY=1 the access executes on the accept edge, so use live request fields in IDLE.
    assign acc_we     = (state == S_IDLE) ? req_we     : lat_we;
    assign acc_signed = (state == S_IDLE) ? req_signed : lat_signed;
    assign acc_addr   = (state == S_IDLE) ? req_addr   : lat_addr;
    assign acc_size   = (state == S_IDLE) ? req_size   : lat_size;
    assign acc_wdata  = (state == S_IDLE) ? req_wdata  : lat_wdata;
    assign wpad_c     = 64'(acc_wdata);

    // Next-state logic; exec_c marks the edge on which the access is performed.
    always_comb begin
        state_nxt = state;
        exec_c    = 1'b0;
        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    if (LATENCY == 1) begin
                        state_nxt = S_RESP;
                        exec_c    = 1'b1;
                    end else begin
                        state_nxt = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt == '0) begin
                    state_nxt = S_RESP;
                    exec_c    = 1'b1;
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Size, alignment and range decode.
    always_comb begin
        nbytes_c = 4'd1 << acc_size;
        base_c   = MEM_AW'(acc_addr);
        err_c    = (32'(nbytes_c) * 8 > DATA_W)
                || ((acc_addr & ADDR_W'(nbytes_c - 4'd1)) != '0)
                || (AX_W'(acc_addr) + AX_W'(nbytes_c) > AX_W'(MEM_BYTES));
    end

    // Little-endian load assembly with zero/sign extension.
    always_comb begin
        logic sgn;
        sgn     = 1'b0;
        ldata_c = '0;
        for (int unsigned i = 0; i < NB_MAX; i++) begin
            if (i == 32'(nbytes_c) - 1) begin
                sgn = mem[base_c + MEM_AW'(i)][7];
            end
        end
        for (int unsigned i = 0; i < NB_MAX; i++) begin
            if (i < 32'(nbytes_c)) begin
                ldata_c[8*i +: 8] = mem[base_c + MEM_AW'(i)];
            end else begin
                ldata_c[8*i +: 8] = {8{acc_signed & sgn}};
            end
        end
        if (err_c || acc_we) begin
            ldata_c = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept_c) begin
                cnt <= CNT_W'(LATENCY - 1);
            end else if (state == S_WAIT) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (exec_c) begin
                resp_valid <= 1'b1;
                resp_rdata <= ldata_c;
                resp_err   <= err_c;
            end else if (state == S_RESP && resp_ready) begin
                resp_valid <= 1'b0;
                resp_rdata <= '0;
                resp_err   <= 1'b0;
            end
        end
    end

    // Request payload; accept_c is already suppressed during reset.
    always_ff @(posedge clk) begin
        if (accept_c) begin
            lat_we     <= req_we;
            lat_signed <= req_signed;
            lat_addr   <= req_addr;
            lat_size   <= req_size;
            lat_wdata  <= req_wdata;
        end
    end

    // Byte-lane store; bytes beyond the access size are left alone.
    always_ff @(posedge clk) begin
        if (exec_c && !reset && acc_we && !err_c) begin
            mem[base_c] <= wpad_c[7:0];
            if (nbytes_c > 4'd1) mem[base_c + MEM_AW'(1)] <= wpad_c[15:8];
            if (nbytes_c > 4'd2) mem[base_c + MEM_AW'(2)] <= wpad_c[23:16];
            if (nbytes_c > 4'd3) mem[base_c + MEM_AW'(3)] <= wpad_c[31:24];
            if (nbytes_c > 4'd4) mem[base_c + MEM_AW'(4)] <= wpad_c[39:32];
            if (nbytes_c > 4'd5) mem[base_c + MEM_AW'(5)] <= wpad_c[47:40];
            if (nbytes_c > 4'd6) mem[base_c + MEM_AW'(6)] <= wpad_c[55:48];
            if (nbytes_c > 4'd7) mem[base_c + MEM_AW'(7)] <= wpad_c[63:56];
        end
    end

    // Combinational instruction fetch; out-of-range words read as zero.
    always_comb begin
        fbase_c = MEM_AW'(fetch_addr);
        if (AX_W'(fetch_addr) + AX_W'(4) > AX_W'(MEM_BYTES)) begin
            fetch_instr = '0;
        end else begin
            fetch_instr = {mem[fbase_c + MEM_AW'(3)], mem[fbase_c + MEM_AW'(2)],
                           mem[fbase_c + MEM_AW'(1)], mem[fbase_c]};
        end
    end

endmodule

// File: tb/tb_tinker_dmem.sv
// Bench for tinker_dmem: transaction-level memory model checked every cycle,
// plus directed loads/stores with literal expectations.
module tb_tinker_dmem;

    localparam int unsigned ADDR_W    = 32;
    localparam int unsigned DATA_W    = 64;
    localparam int unsigned MEM_BYTES = 524288;
    localparam int unsigned LAT       = 2;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_we = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [1:0]        req_size = '0;
    logic              req_signed = 1'b0;
    logic [DATA_W-1:0] req_wdata = '0;
    logic              resp_valid;
    logic              resp_ready = 1'b0;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;
    logic [ADDR_W-1:0] fetch_addr = '0;
    logic [31:0]       fetch_instr;

    always #5 clk = ~clk;

    tinker_dmem #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_BYTES(MEM_BYTES), .LATENCY(LAT)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_size(req_size), .req_signed(req_signed),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .fetch_addr(fetch_addr), .fetch_instr(fetch_instr)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Model: byte store of everything written through the port, one pending transaction.
    logic [7:0]  mm [int unsigned];
    bit          m_busy = 1'b0, m_valid = 1'b0, m_err = 1'b0, m_known = 1'b0;
    logic [63:0] m_rdata = '0;
    int          m_due = 0;
    bit          m_we, m_sgn;
    logic [31:0] m_addr;
    logic [1:0]  m_size;
    logic [63:0] m_wdata;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%h required=0x%h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        int unsigned nb;
        logic [63:0] v;
        cyc++;
        if (reset) begin
            m_busy = 0; m_valid = 0; m_err = 0; m_rdata = '0;
        end else if (m_valid) begin
            if (resp_ready) begin
                m_valid = 0; m_busy = 0;
            end
        end else if (m_busy) begin
            if (cyc == m_due) begin
                nb = 1 << m_size;
                m_err = (m_addr % nb != 0) || (64'(m_addr) + 64'(nb) > 64'(MEM_BYTES))
                     || (nb * 8 > DATA_W);
                m_rdata = '0;
                m_known = 1;
                if (!m_err) begin
                    if (m_we) begin
                        for (int unsigned i = 0; i < nb; i++) mm[m_addr + i] = m_wdata[8*i +: 8];
                    end else begin
                        v = '0;
                        for (int unsigned i = 0; i < nb; i++) begin
                            if (!mm.exists(m_addr + i)) m_known = 0;
                            else v = v | (64'(mm[m_addr + i]) << (8 * i));
                        end
                        if (m_sgn && nb < 8 && v[8*nb-1]) v = v | ~((64'd1 << (8 * nb)) - 64'd1);
                        m_rdata = v;
                    end
                end
                m_valid = 1;
            end
        end else if (req_valid) begin
            m_busy = 1; m_due = cyc + LAT;
            m_we = req_we; m_sgn = req_signed; m_addr = req_addr;
            m_size = req_size; m_wdata = req_wdata;
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        logic [63:0] fa;
        bit known;
        chk("req_ready", 64'(req_ready), 64'(!m_busy && !reset));
        chk("resp_valid", 64'(resp_valid), 64'(m_valid));
        if (m_valid) begin
            chk("resp_err", 64'(resp_err), 64'(m_err));
            if (m_known) chk("resp_rdata", resp_rdata, m_rdata);
        end
        fa = 64'(fetch_addr);
        if (fa + 4 > 64'(MEM_BYTES)) begin
            chk("fetch_oor", 64'(fetch_instr), 64'd0);
        end else begin
            known = 1;
            for (int unsigned j = 0; j < 4; j++) if (!mm.exists(fetch_addr + j)) known = 0;
            if (known) chk("fetch", 64'(fetch_instr),
                           64'({mm[fetch_addr+3], mm[fetch_addr+2], mm[fetch_addr+1], mm[fetch_addr]}));
        end
    end

    task automatic xact(input bit we, input logic [31:0] addr, input logic [1:0] size,
                        input bit sgn, input logic [63:0] wdata, input int hold, input bit pulse,
                        output logic [63:0] rdata, output logic err, output int lat);
        int k;
        bit ok;
        rdata = 'x; err = 1'bx; lat = -1;
        @(posedge clk); #2;
        req_valid = 1; req_we = we; req_addr = addr; req_size = size;
        req_signed = sgn; req_wdata = wdata;
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (req_ready) begin ok = 1; break; end
        end
        if (!ok) begin
            failures++;
            $display("FAIL accept_timeout: req_ready never high for addr 0x%h", addr);
            req_valid = 0;
            return;
        end
        @(posedge clk); #2;
        k = cyc;
        req_valid = 0; req_we = 1'($urandom); req_addr = $urandom;
        req_size = 2'($urandom); req_signed = 1'($urandom); req_wdata = {$urandom, $urandom};
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (resp_valid) begin ok = 1; break; end
        end
        if (!ok) begin
            failures++;
            $display("FAIL resp_timeout: resp_valid never high for addr 0x%h", addr);
            return;
        end
        lat = cyc - k; rdata = resp_rdata; err = resp_err;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #2;
            if (pulse && h == 1) begin
                req_valid = 1; req_we = 1; req_addr = 32'h200; req_size = 2'd3; req_wdata = '0;
            end else begin
                req_valid = 0;
            end
            @(negedge clk);
            chk("hold_rdata", resp_rdata, rdata);
            chk("hold_err", 64'(resp_err), 64'(err));
        end
        @(posedge clk); #2;
        req_valid = 0; resp_ready = 1;
        @(posedge clk); #2;
        resp_ready = 0;
    endtask

    task automatic ld(input logic [31:0] addr, input logic [1:0] size, input bit sgn,
                      input logic [63:0] exp_d, input logic exp_e, input string nm);
        logic [63:0] d; logic e; int l;
        xact(0, addr, size, sgn, '0, 0, 0, d, e, l);
        chk({nm, "_data"}, d, exp_d);
        chk({nm, "_err"}, 64'(e), 64'(exp_e));
    endtask

    task automatic st(input logic [31:0] addr, input logic [1:0] size, input logic [63:0] wd,
                      input logic exp_e, input string nm);
        logic [63:0] d; logic e; int l;
        xact(1, addr, size, 0, wd, 0, 0, d, e, l);
        chk({nm, "_err"}, 64'(e), 64'(exp_e));
        chk({nm, "_rdata"}, d, 64'd0);
    endtask

    initial begin
        logic [63:0] d; logic e; int l; bit ok;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_resp_rdata", resp_rdata, 64'd0);
        chk("rst_resp_err", 64'(resp_err), 64'd0);
        @(posedge clk); #2;
        reset = 0;

        st(32'h200, 2'd3, 64'h5A5A5A5A5A5A5A5A, 0, "pre_200");
        st(32'h7FFFC, 2'd2, 64'h00000000EFBEADDE, 0, "pre_top");

        xact(1, 32'h100, 2'd3, 0, 64'h1122334455667788, 0, 0, d, e, l);
        chk("t1_latency", 64'(l), 64'd2);
        chk("t1_err", 64'(e), 64'd0);
        ld(32'h100, 2'd3, 0, 64'h1122334455667788, 0, "t1_ld64");
        ld(32'h100, 2'd0, 0, 64'h88, 0, "t1_b100");
        ld(32'h107, 2'd0, 0, 64'h11, 0, "t1_b107");

        ld(32'h100, 2'd0, 1, 64'hFFFFFFFFFFFFFF88, 0, "t2_sb");
        ld(32'h106, 2'd1, 0, 64'h1122, 0, "t2_uh");
        ld(32'h102, 2'd1, 1, 64'h5566, 0, "t2_sh_pos");
        ld(32'h7FFFC, 2'd2, 1, 64'hFFFFFFFFEFBEADDE, 0, "t2_sw_neg");

        ld(32'h102, 2'd2, 0, 64'd0, 1, "t3_misalign");
        st(32'h7FFFC, 2'd3, 64'h0, 1, "t3_st_oor");
        ld(32'h7FFFC, 2'd2, 0, 64'hEFBEADDE, 0, "t3_top_intact");
        ld(32'h80000, 2'd0, 0, 64'd0, 1, "t3_past_end");
        ld(32'h7FFFF, 2'd0, 0, 64'hEF, 0, "t3_last_byte");

        xact(0, 32'h200, 2'd3, 0, '0, 5, 1, d, e, l);
        chk("t4_data", d, 64'h5A5A5A5A5A5A5A5A);
        chk("t4_err", 64'(e), 64'd0);
        ld(32'h200, 2'd3, 0, 64'h5A5A5A5A5A5A5A5A, 0, "t4_pulse_ignored");

        // Reset during WAIT drops a pending store.
        @(posedge clk); #2;
        req_valid = 1; req_we = 1; req_addr = 32'h200; req_size = 2'd0; req_wdata = 64'hA5;
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (req_ready) begin ok = 1; break; end
        end
        if (!ok) begin failures++; $display("FAIL t5_accept_timeout"); end
        @(posedge clk); #2;
        req_valid = 0; reset = 1;
        @(posedge clk); #2;
        reset = 0;
        @(negedge clk);
        chk("t5_ready_after_rst", 64'(req_ready), 64'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t5_no_resp", 64'(resp_valid), 64'd0);
        end
        ld(32'h200, 2'd0, 0, 64'h5A, 0, "t5_byte_kept");

        // Reset coinciding with the write edge also suppresses the store.
        @(posedge clk); #2;
        req_valid = 1; req_we = 1; req_addr = 32'h201; req_size = 2'd0; req_wdata = 64'hC3;
        @(negedge clk);
        chk("t5b_ready", 64'(req_ready), 64'd1);
        @(posedge clk); #2;
        req_valid = 0;
        @(posedge clk); #2;
        reset = 1;
        @(posedge clk); #2;
        reset = 0;
        ld(32'h201, 2'd0, 0, 64'h5A, 0, "t5b_byte_kept");

        fetch_addr = 32'h2000;
        st(32'h2000, 2'd2, 64'h8C0000AB, 0, "t6_st");
        @(negedge clk);
        chk("t6_fetch", 64'(fetch_instr), 64'h8C0000AB);
        @(posedge clk); #2;
        fetch_addr = 32'h7FFFE;
        @(negedge clk);
        chk("t6_fetch_oor", 64'(fetch_instr), 64'd0);
        @(posedge clk); #2;
        fetch_addr = 32'h7FFFC;
        @(negedge clk);
        chk("t6_fetch_top", 64'(fetch_instr), 64'hEFBEADDE);

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
